// File: rtl/mprj_pad_pkg.sv
// Shared types for the MPRJ pad sequencer: mode encodings, FSM states,
// configuration payload and the per-pad boot mode table.
package mprj_pad_pkg;

    localparam int unsigned NUM_PADS_DEF = 38;
    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned MODE_W       = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SAFE  = 2'b00,
        MODE_IN    = 2'b01,
        MODE_OUT   = 2'b10,
        MODE_BIDIR = 2'b11
    } pad_mode_e;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_BOOT_WAIT  = 3'd1,
        ST_BOOT_SCAN  = 3'd2,
        ST_IDLE       = 3'd3,
        ST_ISOLATE    = 3'd4,
        ST_APPLY      = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        pad_mode_e         mode;
    } cfg_req_t;

    // Pads 7-21 and 36 boot as inputs, every other pad boots bidirectional.
    function automatic logic [2*NUM_PADS_DEF-1:0] boot_modes();
        logic [2*NUM_PADS_DEF-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NUM_PADS_DEF); i++) begin
            if ((i >= 7 && i <= 21) || i == 36) begin
                m[2*i +: 2] = MODE_IN;
            end else begin
                m[2*i +: 2] = MODE_BIDIR;
            end
        end
        return m;
    endfunction

    localparam logic [2*NUM_PADS_DEF-1:0] DEFAULT_MODE = boot_modes();

endpackage

// File: rtl/mprj_pad_map.sv
// Registered decoder from a committed pad mode (and the core's OEB in
// BIDIR) to the pad cell OEN/REN controls.
module mprj_pad_map (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode_i,
    input  logic       core_oeb_i,
    output logic       oen_o,
    output logic       ren_o
);
    import mprj_pad_pkg::*;

    logic oen_d;
    logic ren_d;
    logic oen_q;
    logic ren_q;

    always_comb begin
        oen_d = 1'b1;
        ren_d = 1'b0;
        case (pad_mode_e'(mode_i))
            MODE_SAFE: begin
                oen_d = 1'b1;
                ren_d = 1'b0;
            end
            MODE_IN: begin
                oen_d = 1'b1;
                ren_d = 1'b1;
            end
            MODE_OUT: begin
                oen_d = 1'b0;
                ren_d = 1'b1;
            end
            MODE_BIDIR: begin
                oen_d = core_oeb_i;
                ren_d = 1'b1;
            end
            default: begin
                oen_d = 1'b1;
                ren_d = 1'b0;
            end
        endcase
    end

    // Reset parks the pad in SAFE (driver off, receiver off).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oen_q <= 1'b1;
            ren_q <= 1'b0;
        end else begin
            oen_q <= oen_d;
            ren_q <= ren_d;
        end
    end

    assign oen_o = oen_q;
    assign ren_o = ren_q;

endmodule

// File: rtl/mprj_pad_sequencer.sv
// MPRJ pad sequencer: staggered boot scan of default pad modes, then
// isolate-then-apply handling of single-pad mode change requests.
module mprj_pad_sequencer #(
    parameter int unsigned          NUM_PADS     = mprj_pad_pkg::NUM_PADS_DEF,
    parameter int unsigned          SETTLE_CYC   = 4,
    parameter int unsigned          BOOT_DLY     = 16,
    parameter int unsigned          STAGGER      = 2,
    parameter logic [2*NUM_PADS-1:0] DEFAULT_MODE = (2*NUM_PADS)'(mprj_pad_pkg::DEFAULT_MODE)
) (
    input  logic                  clock,
    input  logic                  resetb,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [5:0]            cfg_addr,
    input  logic [1:0]            cfg_mode,
    output logic                  cfg_err,
    input  logic [NUM_PADS-1:0]   core_oeb,
    output logic [NUM_PADS-1:0]   pad_oen,
    output logic [NUM_PADS-1:0]   pad_ren,
    output logic [2*NUM_PADS-1:0] pad_mode,
    output logic                  busy
);
    import mprj_pad_pkg::*;

    localparam int unsigned IDX_W   = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int unsigned CNT_MAX = (BOOT_DLY >= SETTLE_CYC && BOOT_DLY >= STAGGER) ? BOOT_DLY :
                                      (SETTLE_CYC >= STAGGER) ? SETTLE_CYC : STAGGER;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [NUM_PADS-1:0][1:0] BOOT_MODE = DEFAULT_MODE;

    seq_state_e               state_q;
    seq_state_e               state_d;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         idx_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic [NUM_PADS-1:0][1:0] mode_q;
    logic [NUM_PADS-1:0][1:0] mode_d;
    cfg_req_t                 req_q;
    cfg_req_t                 req_d;
    logic                     ready_q;
    logic                     ready_d;
    logic                     busy_q;
    logic                     busy_d;
    logic                     err_q;
    logic                     err_d;

    logic                     accept_c;
    logic                     in_range_c;
    logic [IDX_W-1:0]         idx_nxt_c;

    assign accept_c   = cfg_valid & ready_q;
    assign in_range_c = (32'(cfg_addr) < NUM_PADS);
    assign idx_nxt_c  = idx_q + IDX_W'(1);

    // Next-state logic; each pad mode commit happens on the edge that enters
    // the scan window or APPLY, so pad outputs follow one cycle later.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        req_d   = req_q;
        err_d   = 1'b0;

        case (state_q)
            ST_RESET_HOLD: begin
                state_d = ST_BOOT_WAIT;
                cnt_d   = '0;
                idx_d   = '0;
            end
            ST_BOOT_WAIT: begin
                if (cnt_q == CNT_W'(BOOT_DLY - 1)) begin
                    state_d   = ST_BOOT_SCAN;
                    cnt_d     = '0;
                    idx_d     = '0;
                    mode_d[0] = BOOT_MODE[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BOOT_SCAN: begin
                if (cnt_q == CNT_W'(STAGGER - 1)) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(NUM_PADS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d             = idx_nxt_c;
                        mode_d[idx_nxt_c] = BOOT_MODE[idx_nxt_c];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (accept_c) begin
                    if (!in_range_c) begin
                        err_d = 1'b1;
                    end else if (mode_q[cfg_addr] != cfg_mode) begin
                        req_d.addr       = cfg_addr;
                        req_d.mode       = pad_mode_e'(cfg_mode);
                        mode_d[cfg_addr] = MODE_SAFE;
                        cnt_d            = '0;
                        state_d          = ST_ISOLATE;
                    end
                end
            end
            ST_ISOLATE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d             = ST_APPLY;
                    cnt_d               = '0;
                    mode_d[req_q.addr]  = req_q.mode;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_RESET_HOLD;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            req_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_PADS); g++) begin : g_pad
        mprj_pad_map u_map (
            .clk        (clock),
            .rst_n      (resetb),
            .mode_i     (mode_q[g]),
            .core_oeb_i (core_oeb[g]),
            .oen_o      (pad_oen[g]),
            .ren_o      (pad_ren[g])
        );
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign busy      = busy_q;
    assign pad_mode  = mode_q;

endmodule
